// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port among the
// in-order pipeline, load responses (buffered in a small FIFO) and the
// mul/div unit. One writer is granted per cycle; the write is registered.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   pipe_valid/ready/rd/sel/alu/pc/dmem  pipeline writeback request
//   ld_valid/rd/data                  load responses (no back-pressure)
//   md_valid/ready/rd/data            mul/div result request
//   rf_hold                           suppresses all grants this cycle
//   rf_we/waddr/wdata/wsrc            registered RF write (wsrc 0 ld, 1 pipe, 2 md)
//   ldq_count                         load FIFO occupancy
//   ld_overflow                       sticky: load dropped because FIFO was full
module wb_port_arbiter #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned LDQ_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pipe_valid,
   output logic                         pipe_ready,
   input  logic [4:0]                   pipe_rd,
   input  logic [1:0]                   pipe_sel,
   input  logic [XLEN-1:0]              pipe_alu,
   input  logic [XLEN-1:0]              pipe_pc,
   input  logic [XLEN-1:0]              pipe_dmem,
   input  logic                         ld_valid,
   input  logic [4:0]                   ld_rd,
   input  logic [XLEN-1:0]              ld_data,
   input  logic                         md_valid,
   output logic                         md_ready,
   input  logic [4:0]                   md_rd,
   input  logic [XLEN-1:0]              md_data,
   input  logic                         rf_hold,
   output logic                         rf_we,
   output logic [4:0]                   rf_waddr,
   output logic [XLEN-1:0]              rf_wdata,
   output logic [1:0]                   rf_wsrc,
   output logic [$clog2(LDQ_DEPTH):0]   ldq_count,
   output logic                         ld_overflow
);

   localparam int unsigned PW = $clog2(LDQ_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      SRC_LD   = 2'd0,
      SRC_PIPE = 2'd1,
      SRC_MD   = 2'd2
   } src_e;

   src_e            rr_q, rr_d, win;
   logic            gnt_l, gnt_p, gnt_m, any_gnt;
   logic            cand_l, urgent, full, push;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count_q;
   logic [4:0]      ldq_rd   [LDQ_DEPTH];
   logic [XLEN-1:0] ldq_data [LDQ_DEPTH];
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic [XLEN-1:0] pipe_data;

   assign cand_l    = (count_q != '0);
   assign full      = (count_q == CW'(LDQ_DEPTH));
   assign urgent    = (count_q >= CW'(LDQ_DEPTH - 1));
   // A full FIFO can still accept a load when the head is popped in the same cycle.
   assign push      = ld_valid && (!full || gnt_l);
   assign ldq_count = count_q;

   // Round-robin pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= SRC_LD;
      else     rr_q <= rr_d;
   end

   // Grant selection and next round-robin pointer.
   always_comb begin
      gnt_l   = 1'b0;
      gnt_p   = 1'b0;
      gnt_m   = 1'b0;
      any_gnt = 1'b0;
      win     = SRC_LD;
      rr_d    = rr_q;
      if (!rst && !rf_hold) begin
         if (cand_l && urgent) begin
            gnt_l = 1'b1;
         end else begin
            case (rr_q)
               SRC_PIPE: begin
                  if (pipe_valid)    gnt_p = 1'b1;
                  else if (md_valid) gnt_m = 1'b1;
                  else if (cand_l)   gnt_l = 1'b1;
               end
               SRC_MD: begin
                  if (md_valid)        gnt_m = 1'b1;
                  else if (cand_l)     gnt_l = 1'b1;
                  else if (pipe_valid) gnt_p = 1'b1;
               end
               default: begin
                  if (cand_l)          gnt_l = 1'b1;
                  else if (pipe_valid) gnt_p = 1'b1;
                  else if (md_valid)   gnt_m = 1'b1;
               end
            endcase
         end
      end
      if (gnt_l) begin
         any_gnt = 1'b1;
         win     = SRC_LD;
         rr_d    = SRC_PIPE;
      end else if (gnt_p) begin
         any_gnt = 1'b1;
         win     = SRC_PIPE;
         rr_d    = SRC_MD;
      end else if (gnt_m) begin
         any_gnt = 1'b1;
         win     = SRC_MD;
         rr_d    = SRC_LD;
      end
   end

   assign pipe_ready = gnt_p;
   assign md_ready   = gnt_m;

   // Pipeline result select; sel=1 falls back to the ALU result.
   always_comb begin
      case (pipe_sel)
         2'd2:    pipe_data = pipe_pc;
         2'd3:    pipe_data = pipe_dmem;
         default: pipe_data = pipe_alu;
      endcase
   end

   // Winner payload mux.
   always_comb begin
      sel_rd   = ldq_rd[rd_ptr];
      sel_data = ldq_data[rd_ptr];
      if (gnt_p) begin
         sel_rd   = pipe_rd;
         sel_data = pipe_data;
      end else if (gnt_m) begin
         sel_rd   = md_rd;
         sel_data = md_data;
      end
   end

   // Load FIFO storage (data only, no reset needed).
   always_ff @(posedge clk) begin
      if (push) begin
         ldq_rd[wr_ptr]   <= ld_rd;
         ldq_data[wr_ptr] <= ld_data;
      end
   end

   // Load FIFO pointers, occupancy and overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         ld_overflow <= 1'b0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + PW'(1);
         if (gnt_l) rd_ptr <= rd_ptr + PW'(1);
         case ({push, gnt_l})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (ld_valid && full && !gnt_l) ld_overflow <= 1'b1;
      end
   end

   // Registered write stage; rd=0 grants update address/data/source but do not write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         rf_wsrc  <= '0;
      end else if (any_gnt) begin
         rf_we    <= (sel_rd != 5'd0);
         rf_waddr <= sel_rd;
         rf_wdata <= sel_data;
         rf_wsrc  <= 2'(win);
      end else begin
         rf_we <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed table vectors, corner-case sequences
// and randomized traffic checked against a queue-based reference model.
module tb_wb_port_arbiter;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;

   logic            clk, rst;
   logic            pipe_valid, pipe_ready;
   logic [4:0]      pipe_rd;
   logic [1:0]      pipe_sel;
   logic [31:0]     pipe_alu, pipe_pc, pipe_dmem;
   logic            ld_valid;
   logic [4:0]      ld_rd;
   logic [31:0]     ld_data;
   logic            md_valid, md_ready;
   logic [4:0]      md_rd;
   logic [31:0]     md_data;
   logic            rf_hold;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [31:0]     rf_wdata;
   logic [1:0]      rf_wsrc;
   logic [2:0]      ldq_count;
   logic            ld_overflow;

   wb_port_arbiter #(.XLEN(XLEN), .LDQ_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_rd(pipe_rd),
      .pipe_sel(pipe_sel), .pipe_alu(pipe_alu), .pipe_pc(pipe_pc), .pipe_dmem(pipe_dmem),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
      .rf_hold(rf_hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rf_wsrc(rf_wsrc), .ldq_count(ldq_count), .ld_overflow(ld_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   int vectors = 0;
   int miscompares = 0;
   int last_w = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ld_t;

   ld_t         mq[$];
   int          m_rr;
   bit          m_ovf;
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic [1:0]  m_wsrc;

   task automatic model_reset();
      mq.delete();
      m_rr = 0; m_ovf = 1'b0; m_we = 1'b0;
      m_waddr = '0; m_wdata = '0; m_wsrc = '0;
   endtask

   function automatic logic [31:0] pipe_result();
      if (pipe_sel == 2'd2) return pipe_pc;
      if (pipe_sel == 2'd3) return pipe_dmem;
      return pipe_alu;
   endfunction

   // Winner id (0 load, 1 pipe, 2 mul/div) or -1 for no grant.
   function automatic int model_winner();
      bit cand[3];
      if (rst || rf_hold) return -1;
      cand[0] = (mq.size() > 0);
      cand[1] = pipe_valid;
      cand[2] = md_valid;
      if (cand[0] && mq.size() >= DEPTH - 1) return 0;
      for (int k = 0; k < 3; k++) begin
         if (cand[(m_rr + k) % 3]) return (m_rr + k) % 3;
      end
      return -1;
   endfunction

   task automatic model_edge(input int w);
      logic [4:0]  rd;
      logic [31:0] d;
      if (w >= 0) begin
         case (w)
            0:       begin rd = mq[0].rd; d = mq[0].data; end
            1:       begin rd = pipe_rd;  d = pipe_result(); end
            default: begin rd = md_rd;    d = md_data; end
         endcase
         m_we = (rd != 5'd0); m_waddr = rd; m_wdata = d; m_wsrc = 2'(w);
         m_rr = (w + 1) % 3;
         if (w == 0) void'(mq.pop_front());
      end else begin
         m_we = 1'b0;
      end
      if (ld_valid) begin
         if (mq.size() < DEPTH) mq.push_back('{ld_rd, ld_data});
         else                   m_ovf = 1'b1;
      end
   endtask

   // One clock with model comparison; called at posedge+1 with inputs driven.
   task automatic cycle();
      int w;
      #1;
      w = model_winner();
      chk("pipe_ready", 32'(pipe_ready), 32'(w == 1));
      chk("md_ready", 32'(md_ready), 32'(w == 2));
      model_edge(w);
      last_w = w;
      @(posedge clk);
      #1;
      chk("rf_we", 32'(rf_we), 32'(m_we));
      chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("rf_wsrc", 32'(rf_wsrc), 32'(m_wsrc));
      chk("ldq_count", 32'(ldq_count), 32'(mq.size()));
      chk("ld_overflow", 32'(ld_overflow), 32'(m_ovf));
   endtask

   task automatic clr_inputs();
      pipe_valid = 1'b0; pipe_rd = '0; pipe_sel = '0;
      pipe_alu = '0; pipe_pc = '0; pipe_dmem = '0;
      ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
      md_valid = 1'b0; md_rd = '0; md_data = '0;
      rf_hold = 1'b0;
   endtask

   task automatic do_reset();
      clr_inputs();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        pv;
      logic [4:0]  prd;
      logic [1:0]  psel;
      logic [31:0] alu, pc, dmem;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] mdata;
      logic        hold;
      logic        e_pready, e_mready, e_we;
      logic [4:0]  e_waddr;
      logic [31:0] e_wdata;
      logic [1:0]  e_wsrc;
   } vec_t;

   vec_t tbl[9];
   int   found;

   initial begin
      tbl[0] = '{1'b1, 5'd5, 2'd2, 32'hAA, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                 1'b1, 1'b0, 1'b1, 5'd5, 32'h100, 2'd1};
      tbl[1] = '{1'b1, 5'd7, 2'd1, 32'h1234, 32'h8, 32'h9, 1'b0, 5'd0, 32'h0, 1'b0,
                 1'b1, 1'b0, 1'b1, 5'd7, 32'h1234, 2'd1};
      tbl[2] = '{1'b1, 5'd0, 2'd0, 32'h55, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                 1'b1, 1'b0, 1'b0, 5'd0, 32'h55, 2'd1};
      tbl[3] = '{1'b1, 5'd3, 2'd3, 32'h0, 32'h0, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0,
                 1'b1, 1'b0, 1'b1, 5'd3, 32'hDEAD, 2'd1};
      tbl[4] = '{1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                 1'b0, 1'b0, 1'b0, 5'd3, 32'hDEAD, 2'd1};
      tbl[5] = '{1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 32'h77, 1'b0,
                 1'b0, 1'b1, 1'b1, 5'd9, 32'h77, 2'd2};
      tbl[6] = '{1'b1, 5'd4, 2'd2, 32'h0, 32'h44, 32'h0, 1'b1, 5'd10, 32'h88, 1'b1,
                 1'b0, 1'b0, 1'b0, 5'd9, 32'h77, 2'd2};
      tbl[7] = '{1'b1, 5'd4, 2'd2, 32'h0, 32'h44, 32'h0, 1'b1, 5'd10, 32'h88, 1'b0,
                 1'b1, 1'b0, 1'b1, 5'd4, 32'h44, 2'd1};
      tbl[8] = '{1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd10, 32'h88, 1'b0,
                 1'b0, 1'b1, 1'b1, 5'd10, 32'h88, 2'd2};

      clr_inputs();
      rst = 1'b1;
      model_reset();
      pipe_valid = 1'b1; md_valid = 1'b1;
      #2;
      chk("rst_pipe_ready", 32'(pipe_ready), 32'h0);
      chk("rst_md_ready", 32'(md_ready), 32'h0);
      do_reset();
      chk("rst_rf_we", 32'(rf_we), 32'h0);
      chk("rst_rf_waddr", 32'(rf_waddr), 32'h0);
      chk("rst_rf_wdata", rf_wdata, 32'h0);
      chk("rst_rf_wsrc", 32'(rf_wsrc), 32'h0);
      chk("rst_ldq_count", 32'(ldq_count), 32'h0);
      chk("rst_ld_overflow", 32'(ld_overflow), 32'h0);

      // Table-driven directed vectors.
      for (int i = 0; i < 9; i++) begin
         pipe_valid = tbl[i].pv;  pipe_rd = tbl[i].prd; pipe_sel = tbl[i].psel;
         pipe_alu = tbl[i].alu;   pipe_pc = tbl[i].pc;  pipe_dmem = tbl[i].dmem;
         md_valid = tbl[i].mv;    md_rd = tbl[i].mrd;   md_data = tbl[i].mdata;
         rf_hold = tbl[i].hold;
         #1;
         chk($sformatf("tbl%0d_pipe_ready", i), 32'(pipe_ready), 32'(tbl[i].e_pready));
         chk($sformatf("tbl%0d_md_ready", i), 32'(md_ready), 32'(tbl[i].e_mready));
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_rf_we", i), 32'(rf_we), 32'(tbl[i].e_we));
         chk($sformatf("tbl%0d_rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_waddr));
         chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata, tbl[i].e_wdata);
         chk($sformatf("tbl%0d_rf_wsrc", i), 32'(rf_wsrc), 32'(tbl[i].e_wsrc));
      end

      // P and M alternate, then a single load is granted within 3 cycles.
      do_reset();
      pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_sel = 2'd0; pipe_alu = 32'h11;
      md_valid = 1'b1; md_rd = 5'd2; md_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("alt_wsrc", 32'(rf_wsrc), (i % 2 == 0) ? 32'd1 : 32'd2);
      end
      ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hC0FFEE;
      cycle();
      ld_valid = 1'b0;
      found = 0;
      for (int k = 0; k < 3 && found == 0; k++) begin
         cycle();
         if (rf_we && rf_wsrc == 2'd0) found = 1;
      end
      chk("load_within_3", 32'(found), 32'd1);
      chk("load_waddr", 32'(rf_waddr), 32'd12);

      // Continuous loads with P and M valid: FIFO settles at DEPTH-1, loads win.
      do_reset();
      pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_alu = 32'h11;
      md_valid = 1'b1; md_rd = 5'd2; md_data = 32'h22;
      for (int i = 0; i < 12; i++) begin
         ld_valid = 1'b1; ld_rd = 5'(i + 1); ld_data = 32'(i);
         cycle();
      end
      chk("stream_count", 32'(ldq_count), 32'd3);
      chk("stream_ovf", 32'(ld_overflow), 32'd0);
      chk("stream_wsrc", 32'(rf_wsrc), 32'd0);

      // Hold with 5 loads: 5th overflows, only rd 1..4 get written.
      do_reset();
      rf_hold = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         ld_valid = 1'b1; ld_rd = 5'(i); ld_data = 32'(i * 16);
         cycle();
         if (i == 4) begin
            chk("hold_count4", 32'(ldq_count), 32'd4);
            chk("hold_ovf_before", 32'(ld_overflow), 32'd0);
         end
      end
      chk("hold_ovf", 32'(ld_overflow), 32'd1);
      chk("hold_count_full", 32'(ldq_count), 32'd4);
      rf_hold = 1'b0; ld_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cycle();
         chk("drain_waddr", 32'(rf_waddr), 32'(i));
         chk("drain_we", 32'(rf_we), 32'd1);
      end
      cycle();
      chk("drain_done_we", 32'(rf_we), 32'd0);
      chk("drain_ovf_sticky", 32'(ld_overflow), 32'd1);

      // Asynchronous reset mid-stream with count=2 and P valid.
      do_reset();
      pipe_valid = 1'b1; pipe_rd = 5'd6; pipe_sel = 2'd0; pipe_alu = 32'h66;
      cycle();
      rf_hold = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1; ld_rd = 5'(20 + i); ld_data = 32'(i);
         cycle();
      end
      ld_valid = 1'b0;
      chk("midrst_count_before", 32'(ldq_count), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_rf_waddr", 32'(rf_waddr), 32'd0);
      chk("midrst_rf_wdata", rf_wdata, 32'd0);
      chk("midrst_rf_wsrc", 32'(rf_wsrc), 32'd0);
      chk("midrst_count", 32'(ldq_count), 32'd0);
      chk("midrst_pipe_ready", 32'(pipe_ready), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      rf_hold = 1'b0;
      cycle();
      chk("postrst_wsrc", 32'(rf_wsrc), 32'd1);
      chk("postrst_waddr", 32'(rf_waddr), 32'd6);

      // Randomized traffic against the reference model.
      do_reset();
      last_w = -1;
      for (int i = 0; i < 400; i++) begin
         if (!(pipe_valid && last_w != 1)) begin
            pipe_valid = ($urandom_range(0, 9) < 6);
            pipe_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            pipe_sel   = 2'($urandom);
            pipe_alu   = $urandom; pipe_pc = $urandom; pipe_dmem = $urandom;
         end
         if (!(md_valid && last_w != 2)) begin
            md_valid = ($urandom_range(0, 9) < 4);
            md_rd    = 5'($urandom);
            md_data  = $urandom;
         end
         ld_valid = ($urandom_range(0, 9) < 4);
         ld_rd    = 5'($urandom);
         ld_data  = $urandom;
         rf_hold  = ($urandom_range(0, 9) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
